i2c_target_regs: RTL

- I2C target (responder) for the open-drain two-wire bus driven by the Nios V HDMI I2C host (sda_in/scl_in/sda_oe/scl_oe style pins).
- Decodes START/STOP, matches a 7-bit device address, and maps bus transfers onto a byte-wide register access port.
- Sits in fabric next to the pin tri-state buffers. Used for board-level loopback tests and as a small sideband config slave.
- No clock stretching. scl_oe is held low.

---
 rtl/i2c_target_pkg.sv | 25 ++
 rtl/i2c_target_regs_pin_filter.sv | 62 ++++++
 rtl/i2c_target_regs.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

    // Protocol phase of the target
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WR_ACK    = 3'd4,
        READ      = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_t;

    // Level of SDA during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // True when the received address byte (addr[6:0], R/W) selects this device
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr);
    endfunction

endpackage

// File: rtl/i2c_target_regs_pin_filter.sv
// Two-flop synchronizer, glitch filter and edge pulses for one bus pin.
// The filtered level only follows the pin after FILTER_LEN consecutive
// samples disagree with it; rise/fall pulse in the cycle the level changes.
module i2c_pin_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          rise_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;

    // Synchronize the raw pin into the clk domain (idle bus level is high)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
        end
    end

    // Accept a level change only after it has been stable long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 1'b1;
            cnt_r   <= '0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
                rise_r  <= sync2_r;
                fall_r  <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target mapping bus transfers onto a byte-wide register port.
// First written byte sets the register pointer, following bytes are
// register writes; reads stream registers from the pointer onward.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        scl_oe,
    output logic                        sda_oe,
    output logic                        reg_wr,
    output logic                        reg_rd,
    output logic [$clog2(NUM_REGS)-1:0] reg_addr,
    output logic [7:0]                  reg_wdata,
    input  logic [7:0]                  reg_rdata,
    output logic                        busy
);

    localparam int AW = $clog2(NUM_REGS);

    logic scl_f_s, scl_rise_s, scl_fall_s;
    logic sda_f_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    i2c_state_t    state_r;
    logic [7:0]    shift_r;
    logic [3:0]    bit_cnt_r;
    logic          rw_r;
    logic          first_byte_r;
    logic [AW-1:0] ptr_r;
    logic          rd_d1_r;
    logic          sda_oe_r;
    logic          reg_wr_r;
    logic          reg_rd_r;
    logic [AW-1:0] reg_addr_r;
    logic [7:0]    reg_wdata_r;
    logic          busy_r;

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (scl_in),
        .level (scl_f_s),
        .rise  (scl_rise_s),
        .fall  (scl_fall_s)
    );

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (sda_in),
        .level (sda_f_s),
        .rise  (sda_rise_s),
        .fall  (sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_f_s;
    assign stop_s  = sda_rise_s & scl_f_s;

    // Protocol state machine; START/STOP override any bit processing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            shift_r      <= 8'h00;
            bit_cnt_r    <= 4'd0;
            rw_r         <= 1'b0;
            first_byte_r <= 1'b0;
            ptr_r        <= '0;
            rd_d1_r      <= 1'b0;
            sda_oe_r     <= 1'b0;
            reg_wr_r     <= 1'b0;
            reg_rd_r     <= 1'b0;
            reg_addr_r   <= '0;
            reg_wdata_r  <= 8'h00;
            busy_r       <= 1'b0;
        end else begin
            reg_wr_r <= 1'b0;
            reg_rd_r <= 1'b0;
            rd_d1_r  <= reg_rd_r;
            if (start_s) begin
                // busy is kept across a repeated START until the address is re-decoded
                state_r   <= ADDR;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= 1'b0;
            end else if (stop_s) begin
                state_r   <= IDLE;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        sda_oe_r <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
                            shift_r   <= {shift_r[6:0], sda_f_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                            bit_cnt_r <= 4'd0;
                            if (addr_match(shift_r, DEV_ADDR)) begin
                                sda_oe_r <= 1'b1;
                                rw_r     <= shift_r[0];
                                busy_r   <= 1'b1;
                                state_r  <= ADDR_ACK;
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall_s) begin
                            bit_cnt_r <= 4'd0;
                            if (rw_r) begin
                                // SDA stays as-is until the fetched byte drives bit 7
                                reg_rd_r   <= 1'b1;
                                reg_addr_r <= ptr_r;
                                state_r    <= READ;
                            end else begin
                                sda_oe_r     <= 1'b0;
                                first_byte_r <= 1'b1;
                                state_r      <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
                            shift_r   <= {shift_r[6:0], sda_f_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                            bit_cnt_r <= 4'd0;
                            sda_oe_r  <= 1'b1;
                            state_r   <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_rise_s) begin
                            if (first_byte_r) begin
                                ptr_r        <= shift_r[AW-1:0];
                                first_byte_r <= 1'b0;
                            end else begin
                                reg_wr_r    <= 1'b1;
                                reg_addr_r  <= ptr_r;
                                reg_wdata_r <= shift_r;
                                ptr_r       <= ptr_r + AW'(1);
                            end
                        end else if (scl_fall_s) begin
                            sda_oe_r  <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= WRITE;
                        end
                    end
                    READ: begin
                        if (rd_d1_r) begin
                            shift_r   <= reg_rdata;
                            sda_oe_r  <= ~reg_rdata[7];
                            bit_cnt_r <= 4'd0;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd7) begin
                                sda_oe_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= RD_ACK;
                            end else begin
                                shift_r   <= {shift_r[6:0], 1'b0};
                                sda_oe_r  <= ~shift_r[6];
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise_s) begin
                            if (sda_f_s == ACK) begin
                                ptr_r <= ptr_r + AW'(1);
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= WAIT_STOP;
                            end
                        end else if (scl_fall_s) begin
                            // only reachable after an ACK rise
                            reg_rd_r   <= 1'b1;
                            reg_addr_r <= ptr_r;
                            bit_cnt_r  <= 4'd0;
                            state_r    <= READ;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe_r <= 1'b0;
                    end
                    default: begin
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign scl_oe    = 1'b0;
    assign sda_oe    = sda_oe_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign busy      = busy_r;

endmodule
